matrix_sequencer: RTL and testbench

MATRIX_SEQUENCER -- requirements
Module: matrix_sequencer

---
 rtl/matrix_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_matrix_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matrix_sequencer                                                |
// | Purpose  : Mode/count sequencer for a multiplexed dot matrix. A slow tick  |
// |            steps a count through 1..MODE_LEN(mode), then moves to the next |
// |            mode. An independent scan divider walks the matrix rows and     |
// |            registers row drive and column data. The count is also shown on |
// |            a seven-segment digit.                                          |
// | Ports    : clk_i      - clock, rising edge                                 |
// |            rst_ni     - asynchronous active-low reset                      |
// |            step_i     - advance to the next mode at once                   |
// |            pause_i    - freeze sequencing (SEQ_PAUSE_EN builds only)       |
// |            pat_col_i  - column pattern for {mode_o,row_idx_o} from ROM     |
// |            mode_o     - current mode index                                 |
// |            count_o    - count within the mode, 1..MODE_LEN                 |
// |            tick_o     - one-cycle pulse per count tick                     |
// |            row_idx_o  - current scan row                                   |
// |            dot_row_o  - active-low one-hot row drive (registered)          |
// |            dot_col_o  - active-high column data (registered)               |
// |            out_o      - active-low seven-segment {g..a} of count_o         |
// | Config   : define SEQ_PAUSE_EN to add the pause_i input                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module matrix_sequencer #(
  parameter int TICK_DIV  = 50000000,
  parameter int SCAN_DIV  = 5000,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int NUM_MODES = 3,
  parameter logic [4*NUM_MODES-1:0] MODE_LENS = {4'd10, 4'd5, 4'd15}
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     step_i,
`ifdef SEQ_PAUSE_EN
  input  logic                     pause_i,
`endif
  input  logic [COLS-1:0]          pat_col_i,
  output logic [1:0]               mode_o,
  output logic [3:0]               count_o,
  output logic                     tick_o,
  output logic [$clog2(ROWS)-1:0]  row_idx_o,
  output logic [ROWS-1:0]          dot_row_o,
  output logic [COLS-1:0]          dot_col_o,
  output logic [6:0]               out_o
);

  localparam int c_TW = $clog2(TICK_DIV);
  localparam int c_SW = $clog2(SCAN_DIV);
  localparam int c_RW = $clog2(ROWS);

  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);
  localparam logic [c_SW-1:0] c_SCAN_LAST = c_SW'(SCAN_DIV - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST  = c_RW'(ROWS - 1);
  localparam logic [1:0]      c_MODE_LAST = 2'(NUM_MODES - 1);
  // Zero-padded to four entries so any 2-bit mode index selects in range.
  localparam logic [15:0]     c_LENS      = 16'(MODE_LENS);

  logic [c_TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [c_SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [c_RW-1:0] row_q,      row_d;
  logic [1:0]      mode_q,     mode_d;
  logic [3:0]      count_q,    count_d;
  logic [ROWS-1:0] dot_row_q,  dot_row_d;
  logic [COLS-1:0] dot_col_q;

  logic       w_run;
  logic       w_tick_term;
  logic [1:0] w_mode_next;
  logic [3:0] w_len_sel;
  logic [3:0] w_mode_len;

`ifdef SEQ_PAUSE_EN
  assign w_run = ~pause_i;
`else
  assign w_run = 1'b1;
`endif

  assign w_tick_term = (tick_cnt_q == c_TICK_LAST);
  assign w_mode_next = (mode_q == c_MODE_LAST) ? 2'd0 : mode_q + 2'd1;
  assign w_len_sel   = {mode_q, 2'b00};
  assign w_mode_len  = c_LENS[w_len_sel +: 4];

  // Pause also masks the tick pulse, not just its effect.
  assign tick_o = w_tick_term & w_run;

  // Sequencing: step has priority and absorbs a coincident tick, so a
  // simultaneous step+tick yields exactly one mode advance.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    mode_d     = mode_q;
    count_d    = count_q;
    if (step_i) begin
      mode_d     = w_mode_next;
      count_d    = 4'd1;
      tick_cnt_d = '0;
    end else if (w_run) begin
      if (w_tick_term) begin
        tick_cnt_d = '0;
        if (count_q < w_mode_len) begin
          count_d = count_q + 4'd1;
        end else begin
          mode_d  = w_mode_next;
          count_d = 4'd1;
        end
      end else begin
        tick_cnt_d = tick_cnt_q + c_TW'(1);
      end
    end
  end

  // Row scanning runs free of mode changes and pause.
  always_comb begin
    scan_cnt_d = scan_cnt_q + c_SW'(1);
    row_d      = row_q;
    if (scan_cnt_q == c_SCAN_LAST) begin
      scan_cnt_d = '0;
      row_d      = (row_q == c_ROW_LAST) ? '0 : row_q + c_RW'(1);
    end
  end

  // Row ROWS-1-row_q is driven low; registering it alongside pat_col_i keeps
  // row drive and column data aligned one cycle behind row_idx_o.
  always_comb begin
    dot_row_d = '1;
    for (int i = 0; i < ROWS; i++) begin
      dot_row_d[i] = (row_q != c_RW'(ROWS - 1 - i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      row_q      <= '0;
      mode_q     <= 2'd0;
      count_q    <= 4'd1;
      dot_row_q  <= '1;
      dot_col_q  <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      row_q      <= row_d;
      mode_q     <= mode_d;
      count_q    <= count_d;
      dot_row_q  <= dot_row_d;
      dot_col_q  <= pat_col_i;
    end
  end

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    out_o = 7'b1111111;
    case (count_q)
      4'h0: out_o = 7'b1000000;
      4'h1: out_o = 7'b1111001;
      4'h2: out_o = 7'b0100100;
      4'h3: out_o = 7'b0110000;
      4'h4: out_o = 7'b0011001;
      4'h5: out_o = 7'b0010010;
      4'h6: out_o = 7'b0000010;
      4'h7: out_o = 7'b1111000;
      4'h8: out_o = 7'b0000000;
      4'h9: out_o = 7'b0010000;
      4'hA: out_o = 7'b0001000;
      4'hB: out_o = 7'b0000011;
      4'hC: out_o = 7'b1000110;
      4'hD: out_o = 7'b0100001;
      4'hE: out_o = 7'b0000110;
      4'hF: out_o = 7'b0001110;
      default: out_o = 7'b1111111;
    endcase
  end

  assign mode_o    = mode_q;
  assign count_o   = count_q;
  assign row_idx_o = row_q;
  assign dot_row_o = dot_row_q;
  assign dot_col_o = dot_col_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_matrix_sequencer                                             |
// | Purpose  : Self-checking bench for matrix_sequencer with a small reference |
// |            model feeding an expected-output queue.                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_matrix_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       step  = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] pat_col;
  logic [1:0] mode;
  logic [3:0] count;
  logic       tick;
  logic [2:0] row_idx;
  logic [7:0] dot_row;
  logic [7:0] dot_col;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External pattern ROM: column data is the row index itself.
  assign pat_col = {5'b0, row_idx};

  matrix_sequencer #(
    .TICK_DIV (4),
    .SCAN_DIV (2),
    .ROWS     (8),
    .COLS     (8),
    .NUM_MODES(3),
    .MODE_LENS({4'd3, 4'd2, 4'd4})
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .step_i   (step),
`ifdef SEQ_PAUSE_EN
    .pause_i  (pause),
`endif
    .pat_col_i(pat_col),
    .mode_o   (mode),
    .count_o  (count),
    .tick_o   (tick),
    .row_idx_o(row_idx),
    .dot_row_o(dot_row),
    .dot_col_o(dot_col),
    .out_o    (seg)
  );

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] count;
    logic       tick;
    logic [2:0] row;
    logic [7:0] drow;
    logic [7:0] dcol;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  int         m_tick, m_count, m_mode, m_scan, m_row;
  logic [7:0] m_drow, m_dcol;
  int         mode_len [3] = '{4, 2, 3};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg7(input int v);
    case (v)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  15: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_tick = 0; m_count = 1; m_mode = 0; m_scan = 0; m_row = 0;
    m_drow = 8'hFF; m_dcol = 8'h00;
  endtask

  task automatic model_step();
    m_drow = ~(8'h80 >> m_row);
    m_dcol = 8'(m_row);
    if (step) begin
      m_mode = (m_mode + 1) % 3; m_count = 1; m_tick = 0;
    end else if (!pause) begin
      if (m_tick == 3) begin
        m_tick = 0;
        if (m_count < mode_len[m_mode]) m_count++;
        else begin m_mode = (m_mode + 1) % 3; m_count = 1; end
      end else m_tick++;
    end
    if (m_scan == 1) begin m_scan = 0; m_row = (m_row + 1) % 8; end
    else m_scan++;
  endtask

  task automatic reset_consts(input string tag);
    check_val({tag, "_mode"},  32'(mode),    32'd0);
    check_val({tag, "_count"}, 32'(count),   32'd1);
    check_val({tag, "_tick"},  32'(tick),    32'd0);
    check_val({tag, "_row"},   32'(row_idx), 32'd0);
    check_val({tag, "_drow"},  32'(dot_row), 32'hFF);
    check_val({tag, "_dcol"},  32'(dot_col), 32'h00);
    check_val({tag, "_seg"},   32'(seg),     32'b1111001);
  endtask

  // One clock: model advances on the edge, expectation is queued, then
  // popped and compared against the DUT on the following falling edge.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    e.mode  = 2'(m_mode);
    e.count = 4'(m_count);
    e.tick  = (m_tick == 3) && !pause;
    e.row   = 3'(m_row);
    e.drow  = m_drow;
    e.dcol  = m_dcol;
    e.seg   = seg7(m_count);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check_val("mode",    32'(mode),    32'(e.mode));
    check_val("count",   32'(count),   32'(e.count));
    check_val("tick",    32'(tick),    32'(e.tick));
    check_val("row_idx", 32'(row_idx), 32'(e.row));
    check_val("dot_row", 32'(dot_row), 32'(e.drow));
    check_val("dot_col", 32'(dot_col), 32'(e.dcol));
    check_val("seg",     32'(seg),     32'(e.seg));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] tbl_mode  [10] = '{0, 0, 0, 1, 1, 2, 2, 2, 0, 0};
    logic [3:0] tbl_count [10] = '{2, 3, 4, 1, 2, 1, 2, 3, 1, 2};
    int guard;

    model_reset();
    #2 rst_n = 1'b0;
    #1 reset_consts("por");
    cycle();
    cycle();
    rst_n = 1'b1;

    // Free run: mode/count after every fourth edge from a fixed table.
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (i % 4 == 0) begin
        check_val("run_mode",  32'(mode),  32'(tbl_mode[i/4-1]));
        check_val("run_count", 32'(count), 32'(tbl_count[i/4-1]));
      end
    end

    // Step coincident with tick at mode0 count2.
    for (int i = 0; i < 3; i++) cycle();
    check_val("pre_step_tick",  32'(tick),  32'd1);
    check_val("pre_step_count", 32'(count), 32'd2);
    step = 1'b1;
    cycle();
    step = 1'b0;
    check_val("step_mode",  32'(mode),  32'd1);
    check_val("step_count", 32'(count), 32'd1);
    check_val("step_tick",  32'(tick),  32'd0);
    for (int i = 0; i < 6; i++) cycle();

`ifdef SEQ_PAUSE_EN
    guard = 0;
    while ((m_mode != 0 || m_count != 2) && guard < 40) begin
      cycle();
      guard++;
    end
    check_val("pause_setup", 32'(count), 32'd2);
    pause = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    check_val("pause_mode",  32'(mode),  32'd0);
    check_val("pause_count", 32'(count), 32'd2);
    step = 1'b1;
    cycle();
    step = 1'b0;
    check_val("pause_step_mode", 32'(mode), 32'd1);
    for (int i = 0; i < 5; i++) cycle();
    pause = 1'b0;
`endif

    // Random step (and pause) traffic against the model.
    for (int i = 0; i < 80; i++) begin
      step = ($urandom_range(0, 7) == 0);
`ifdef SEQ_PAUSE_EN
      pause = ($urandom_range(0, 5) == 0);
`endif
      cycle();
    end
    step  = 1'b0;
    pause = 1'b0;

    // Reach mode2 count3, then reset mid-row.
    guard = 0;
    while (m_mode != 2 && guard < 4) begin
      step = 1'b1;
      cycle();
      step = 1'b0;
      guard++;
    end
    guard = 0;
    while (m_count != 3 && guard < 20) begin
      cycle();
      guard++;
    end
    check_val("pre_rst_mode",  32'(mode),  32'd2);
    check_val("pre_rst_count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1 reset_consts("mid_rst");
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) cycle();

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
